// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbiter: RAM status codes, data word,
// arbiter FSM states and grant identifiers.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational grant picker for the icache/dcache arbiter.
// With CACHE_ARB_FAIR_EN defined, simultaneous requests alternate based on
// last_grant; otherwise the dcache always wins. The output is only
// meaningful when at least one request is present.
module cache_arb_pick
  import cpu_types_pkg::*;
(
  input  logic   ireq,
  input  logic   dreq,
  input  grant_t last_grant,
  output grant_t gnt
);

`ifdef CACHE_ARB_FAIR_EN
  // Round-robin on contention, single requester always wins.
  always_comb begin
    gnt = GNT_I;
    if (ireq && dreq)
      gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
    else if (dreq)
      gnt = GNT_D;
  end
`else
  // Fixed priority: dcache first. last_grant plays no role here.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    gnt = GNT_I;
    if (dreq)
      gnt = GNT_D;
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one RAM port between icache reads and dcache reads/writes.
// One RAM transaction outstanding at a time; every grant passes through IDLE
// for one arbitration cycle. Completion (wait low, load valid) is
// combinational from ramstate==ACCESS while the owner holds the grant.
// Optional macro CACHE_ARB_FAIR_EN: alternate grants on simultaneous
// requests instead of fixed dcache priority.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  arb_state_t state;
  logic       op_write;
  ramstate_t  rs;
  grant_t     gnt;
  grant_t     last_grant;
  logic       dreq;
  logic       owner_req;
  logic       done;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  // Grant holder's request is still live; dropping it aborts the access.
  assign owner_req = (state == DGNT) ? dreq : iREN;
  assign done      = (rs == ACCESS);

`ifdef CACHE_ARB_FAIR_EN
  // Remember who was granted last so contention alternates.
  always_ff @(posedge CLK) begin
    if (RST)
      last_grant <= GNT_I;
    else if (state == IDLE && (dreq || iREN))
      last_grant <= gnt;
  end
`else
  assign last_grant = GNT_I;
`endif

  cache_arb_pick u_pick (
    .ireq       (iREN),
    .dreq       (dreq),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Arbitration FSM. ramaddr/ramstore are loaded once at the grant edge and
  // then held, so they double as the latched request address/data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op_write <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dreq || iREN) begin
            if (gnt == GNT_D) begin
              state    <= DGNT;
              op_write <= dWEN;
              ramREN   <= ~dWEN;
              ramWEN   <= dWEN;
              ramaddr  <= daddr;
              ramstore <= dstore;
            end else begin
              state    <= IGNT;
              op_write <= 1'b0;
              ramREN   <= 1'b1;
              ramWEN   <= 1'b0;
              ramaddr  <= iaddr;
              ramstore <= '0;
            end
          end
        end
        DGNT, IGNT: begin
          // Completion, RAM error (retry via re-arbitration) or abort all
          // release the port; BUSY/FREE hold.
          if (done || rs == ERROR || !owner_req) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

  // Completion handshake: owner's wait drops for the ACCESS cycle only.
  always_comb begin
    iwait = 1'b1;
    dwait = 1'b1;
    iload = '0;
    dload = '0;
    if (done && state == IGNT) begin
      iwait = 1'b0;
      iload = ramload;
    end
    if (done && state == DGNT) begin
      dwait = 1'b0;
      if (!op_write)
        dload = ramload;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter. Inputs are changed
// 1 ns after the rising edge; outputs are checked 1 ns after that.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  logic        first_d;
  logic [31:0] a_first, a_second;

  initial begin
    RST = 1'b1; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0;
    dstore = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    RST = 1'b0; settle();

    // Reset values
    chk("rst_iwait",  iwait,  1'b1);
    chk("rst_dwait",  dwait,  1'b1);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload",  iload,  32'h0);
    chk("rst_dload",  dload,  32'h0);

    // Icache read: two BUSY cycles then ACCESS at cycle 3
    iREN = 1; iaddr = 32'h40; tick();
    ramstate = BUSY; settle();
    chk("ird_c1_ramREN",  ramREN,  1'b1);
    chk("ird_c1_ramaddr", ramaddr, 32'h40);
    chk("ird_c1_iwait",   iwait,   1'b1);
    tick(); settle();
    chk("ird_c2_iwait", iwait, 1'b1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF; iREN = 0; settle();
    chk("ird_c3_iwait", iwait, 1'b0);
    chk("ird_c3_iload", iload, 32'hDEADBEEF);
    chk("ird_c3_dwait", dwait, 1'b1);
    tick();
    ramstate = FREE; settle();
    chk("ird_c4_iwait",  iwait,  1'b1);
    chk("ird_c4_iload",  iload,  32'h0);
    chk("ird_c4_ramREN", ramREN, 1'b0);

    // Dcache write with a live address change during the grant
    dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; tick();
    daddr = 32'h84; ramstate = BUSY; settle();
    chk("dwr_ramWEN",   ramWEN,   1'b1);
    chk("dwr_ramREN",   ramREN,   1'b0);
    chk("dwr_ramaddr",  ramaddr,  32'h80);
    chk("dwr_ramstore", ramstore, 32'h12345678);
    chk("dwr_busy_dwait", dwait, 1'b1);
    tick(); settle();
    chk("dwr_hold_ramaddr", ramaddr, 32'h80);
    ramstate = ACCESS; ramload = 32'hCAFEF00D; settle();
    chk("dwr_done_dwait", dwait, 1'b0);
    chk("dwr_done_dload", dload, 32'h0);
    chk("dwr_done_iwait", iwait, 1'b1);
    dWEN = 0; tick();
    ramstate = FREE; settle();
    chk("dwr_idle_ramWEN", ramWEN, 1'b0);
    chk("dwr_idle_dwait",  dwait,  1'b1);

    // Simultaneous requests; the last grant was to the dcache
`ifdef CACHE_ARB_FAIR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a_first  = first_d ? 32'h200 : 32'h100;
    a_second = first_d ? 32'h100 : 32'h200;
    iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; tick();
    ramstate = ACCESS; ramload = 32'h11111111; settle();
    chk("sim1_ramaddr", ramaddr, a_first);
    chk("sim1_ramREN",  ramREN,  1'b1);
    chk("sim1_dwait",   dwait,   !first_d);
    chk("sim1_iwait",   iwait,   first_d);
    chk("sim1_dload",   dload,   first_d ? 32'h11111111 : 32'h0);
    chk("sim1_iload",   iload,   first_d ? 32'h0 : 32'h11111111);
    if (first_d) dREN = 0; else iREN = 0;
    tick();
    ramstate = FREE; settle();
    chk("sim_gap_ramREN", ramREN, 1'b0);
    chk("sim_gap_iwait",  iwait,  1'b1);
    chk("sim_gap_dwait",  dwait,  1'b1);
    tick();
    ramstate = ACCESS; ramload = 32'h22222222; settle();
    chk("sim2_ramaddr", ramaddr, a_second);
    chk("sim2_dwait",   dwait,   first_d);
    chk("sim2_iwait",   iwait,   !first_d);
    chk("sim2_load",    first_d ? iload : dload, 32'h22222222);
    iREN = 0; dREN = 0; tick();
    ramstate = FREE; settle();

    // RAM error during icache grant: retry then complete
    iREN = 1; iaddr = 32'h44; tick();
    ramstate = ERROR; settle();
    chk("err_ramREN", ramREN, 1'b1);
    chk("err_iwait",  iwait,  1'b1);
    tick();
    ramstate = FREE; settle();
    chk("err_idle_ramREN", ramREN, 1'b0);
    chk("err_idle_iwait",  iwait,  1'b1);
    tick();
    ramstate = ACCESS; ramload = 32'h55; settle();
    chk("err_retry_ramaddr", ramaddr, 32'h44);
    chk("err_retry_iwait",   iwait,   1'b0);
    chk("err_retry_iload",   iload,   32'h55);
    iREN = 0; tick();
    ramstate = FREE; settle();

    // Abort: dcache drops its read while RAM is busy
    dREN = 1; daddr = 32'h88; tick();
    ramstate = BUSY; settle();
    chk("abt_ramREN", ramREN, 1'b1);
    tick();
    dREN = 0; settle();
    chk("abt_drop_dwait", dwait, 1'b1);
    tick();
    ramstate = ACCESS; settle();
    chk("abt_ramREN_off", ramREN, 1'b0);
    chk("abt_no_pulse",   dwait,  1'b1);
    chk("abt_no_dload",   dload,  32'h0);
    ramstate = FREE; tick();

    // Reset mid-transaction
    dREN = 1; daddr = 32'h90; tick();
    ramstate = BUSY; settle();
    chk("rmid_ramREN", ramREN, 1'b1);
    RST = 1; dREN = 0; tick(); tick();
    RST = 0; settle();
    chk("rmid_ramREN_off", ramREN, 1'b0);
    chk("rmid_dwait", dwait, 1'b1);
    chk("rmid_iwait", iwait, 1'b1);
    chk("rmid_state", dut.state, IDLE);
    chk("rmid_ramaddr", ramaddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between the icache and dcache request interfaces.
- Sits between the caches block and the RAM model/controller.
- Serialises requests: one outstanding RAM transaction at a time.
- Default priority is dcache first. Returns wait/load per requester.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache address
iwait  out  1  low for exactly the cycle an icache read completes
iload  out  DATA_W  icache read data, valid when iwait=0
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache address
dstore  in  DATA_W  dcache write data
dwait  out  1  low for exactly the cycle a dcache access completes
dload  out  DATA_W  dcache read data, valid when dwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (CLK, RST).
  - RST has priority over all other inputs.
- Reset values:
  - state=IDLE.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0.
  - ramaddr=0, ramstore=0, iload=0, dload=0.
  - Latched op/addr/data=0, last_grant=I.
- FSM states: IDLE, DGNT, IGNT.
- IDLE:
  - If dREN|dWEN, go to DGNT; latch op (write if dWEN, else read), daddr, dstore.
  - Else if iREN, go to IGNT; latch iaddr.
  - Else stay.
  - RAM strobes are 0 in IDLE. Every grant therefore costs one arbitration cycle.
- DGNT/IGNT:
  - Drive ramaddr/ramstore/ramREN/ramWEN from the latched values.
  - Live requester addr/data changes are ignored until the next grant.
  - ramstate==ACCESS: complete. The owner's wait=0 that cycle (combinational from ramstate). dload/iload=ramload for a read; otherwise 0. Next state is IDLE.
  - ramstate==BUSY or FREE: hold, wait=1.
  - ramstate==ERROR: no completion, wait stays 1. Return to IDLE; the request is re-arbitrated (retry).
  - Owner drops its request before ACCESS: abort. RAM strobes go to 0 from the next cycle, state returns to IDLE, no completion pulse.
- Non-owner wait is always 1. iload/dload are 0 except during their own completion cycle.
- Minimum latency: request at cycle 0, grant edge, earliest completion cycle 1. Back-to-back same requester: completion every 2 cycles minimum.
- dREN and dWEN both high: write wins; treat as a protocol error, no flag required.
- Simultaneous iREN and dREN/dWEN in IDLE: dcache wins (without macro). The icache waits with iwait=1 until the dcache completes.
- Addresses are not modified, aligned or masked by this block.

Optional Feature:
- Macro: CACHE_ARB_FAIR_EN.
- Defined: on simultaneous i/d requests in IDLE, the requester not granted last wins; last_grant updates on every grant. A single requester is granted regardless of last_grant.
- Undefined: fixed dcache priority; last_grant is not implemented.

Decomposition:
- cpu_types_pkg holds:
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}
  - word_t
  - arb_state_t enum {IDLE, DGNT, IGNT}
  - grant_t enum {GNT_I, GNT_D}
- One natural sub-module: cache_arb_pick. It is a combinational picker: inputs are the request bits and last_grant; output is the grant. It isolates the CACHE_ARB_FAIR_EN difference.

Test Plan:
- Reset → outputs and state: RST high 2 cycles mid-transaction (DGNT, ramREN=1) → next edge ramREN=0, dwait=1, iwait=1, state IDLE.
- Icache read: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1 with ramaddr=0x40 from cycle 1; iwait=0 and iload=0xDEADBEEF exactly at cycle 3.
- Dcache write: dWEN=1, daddr=0x80, dstore=0x12345678 → ramWEN=1, ramaddr=0x80, ramstore=0x12345678; dwait=0 one cycle on ACCESS; dload=0.
- Simultaneous requests: iREN=1 and dREN=1 at the same cycle:
  - Without the macro: dcache is served first, then the icache after one IDLE cycle.
  - With CACHE_ARB_FAIR_EN after a prior D grant: the icache is served first.
- ERROR and abort:
  - ramstate=ERROR during IGNT → iwait stays 1, FSM re-grants, second attempt completes on ACCESS.
  - Separately, dREN dropped during BUSY → ramREN=0 next cycle, no dwait pulse.
- Address stability: change daddr from 0x80 to 0x84 during DGNT → ramaddr holds 0x80 until completion.
